stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Synchronous control sequencer for the stopwatch. It takes the raw active-low start_pause and display_stop_continue buttons and conditions them with a synchronizer and debounce stage. A run/pause/done state machine then drives the time-count datapath with a single-cycle count-enable tick and the display register with a live/frozen (lap) enable. The block sits between the board buttons and the time counter/display modules, and all of them share its clock and reset.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized cycles required to accept a button level change (20 ms at 50 MHz); must be ≥ 2
- TICK_DIV, 500_000: clock cycles per count_en tick (100 Hz at 50 MHz); must be ≥ 2
- clk  input  1  system clock; all state is updated on its rising edge
- reset  input  1  asynchronous, active-low reset
- start_pause  input  1  raw button, active-low, asynchronous to clk
- display_stop_continue  input  1  raw button, active-low, asynchronous to clk
- max_reached  input  1  from datapath, high while the count equals its maximum value (59:59.99)
- count_en  output  1  one-cycle pulse; advance the time count by one unit
- running  output  1  high in RUN state
- display  output  1  1 = display register loads every cycle (live); 0 = display frozen (lap)
- state  output  2  current FSM state code

## Operation
- Button path, one path per button: 2-flop synchronizer, then the debouncer.
  - The debouncer holds the accepted level, which is 1 (released) at reset.
  - A counter increments while the synchronized level differs from the accepted level. It clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - An accepted 1→0 transition produces a press pulse, 1 cycle long. Releases produce no pulse.
- FSM states: PAUSED (reset state), RUN, DONE.
  - PAUSED + start press → RUN.
  - RUN + start press → PAUSED.
  - RUN + max_reached → DONE. max_reached has priority over a start press in the same cycle.
  - DONE ignores start presses and leaves only through reset.
  - max_reached in PAUSED is ignored.
- Prescaler: 0..TICK_DIV-1.
  - Increments only in RUN and wraps to 0.
  - Holds its value in PAUSED and DONE, so the fractional unit is preserved across pause.
  - count_en = (state==RUN) && prescaler==TICK_DIV-1. It is evaluated on the current state, so a tick that coincides with a pause press is still issued.
- Display flag: toggles on each display press in every state, including DONE.
- Simultaneous start and display presses in one cycle: both are applied.
- Reset (asynchronous, any time, including mid-debounce or mid-tick):
  - state=PAUSED, prescaler=0, debounce counters=0, accepted levels=1, synchronizers=1.
  - Outputs: count_en=0, running=0, display=1, state=PAUSED.

## Timing
- Raw button edge to press pulse: 2 synchronizer cycles plus DEBOUNCE_CYCLES cycles.
- State, running and display update on the clock edge after the press pulse.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles are rejected. A re-match clears the counter.
- First count_en after entering RUN from reset: TICK_DIV cycles after the state change, then every TICK_DIV cycles.
- count_en is never high in consecutive cycles and is never high in PAUSED or DONE.
- All outputs are registered or decoded directly from registers, with no combinational input-to-output path.

## Structure
- Package stopwatch_pkg:
  - State codes: PAUSED=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to PAUSED.
  - Default DEBOUNCE_CYCLES and TICK_DIV constants.
  - Counter widths, derived with $clog2.
- Sub-module button_debounce: synchronizer, debouncer and press-pulse generator, parameterized by DEBOUNCE_CYCLES. It is instantiated twice.
- The FSM, prescaler and display flag live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TICK_DIV=5.
- Start: release reset, hold start_pause low for 10 cycles → running=1 exactly 7 cycles after the falling edge, then count_en every 5th cycle.
- Glitch rejection: pulse start_pause low for 3 cycles → no state change, debounce counter returns to 0.
- Pause preserves the prescaler: press start while the prescaler is at 2, then resume → first count_en 2 cycles after the resume (prescaler at 3, 4).
- Lap freeze: while in RUN, press display_stop_continue → display=0 while count_en continues. Press again → display=1.
- Overflow: in RUN, raise max_reached together with a start press → state=DONE, no further count_en, later start presses ignored, reset → PAUSED with display=1.
- Mid-operation reset: assert reset with the prescaler at 3 and a debounce in progress → all outputs take their reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control sequencer.
//   - sw_state_e : FSM state codes (2'b11 is unused and recovers to PAUSED)
//   - DEF_DEBOUNCE_CYCLES / DEF_TICK_DIV : defaults for a 50 MHz clock
//   - cnt_w()    : width of a counter that holds 0..n-1
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'b00,
    ST_RUN    = 2'b01,
    ST_DONE   = 2'b10
  } sw_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at 50 MHz
  localparam int unsigned DEF_TICK_DIV        = 500_000;    // 100 Hz at 50 MHz

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_DEB_W  = cnt_w(DEF_DEBOUNCE_CYCLES);
  localparam int unsigned DEF_TICK_W = cnt_w(DEF_TICK_DIV);

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller, the board buttons and the
// time-count / display datapath.
//   start_pause, display_stop_continue : raw active-low buttons
//   max_reached : count is at 59:59.99
//   count_en    : one-cycle advance pulse
//   running     : FSM is in RUN
//   display     : 1 = display live, 0 = frozen (lap)
//   state       : current FSM state code
// master: environment side (buttons + datapath); slave: the controller.
interface stopwatch_ctrl_if;
  logic       start_pause;
  logic       display_stop_continue;
  logic       max_reached;
  logic       count_en;
  logic       running;
  logic       display;
  logic [1:0] state;

  modport master (
    output start_pause, display_stop_continue, max_reached,
    input  count_en, running, display, state
  );

  modport slave (
    input  start_pause, display_stop_continue, max_reached,
    output count_en, running, display, state
  );
endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// button_debounce: 2-flop synchronizer, level debouncer and press-pulse
// generator for one raw active-low button.
//   clk, reset : system clock, asynchronous active-low reset
//   btn_n_i    : raw button level (asynchronous, active-low)
//   press_o    : registered one-cycle pulse on an accepted press (1->0)
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int unsigned   CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized level disagrees with the
  // accepted one; any re-match clears it, so a glitch must be stable for
  // DEBOUNCE_CYCLES consecutive cycles to be accepted.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning plus the PAUSED/RUN/DONE sequencer.
// Drives the time counter with a one-cycle count_en tick every TICK_DIV
// cycles in RUN and the display register with a live/frozen flag.
//   clk, reset : system clock, asynchronous active-low reset
//   sw         : stopwatch_ctrl_if.slave (buttons, max_reached in;
//                count_en, running, display, state out)
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TICK_DIV        = DEF_TICK_DIV
) (
  input logic              clk,
  input logic              reset,
  stopwatch_ctrl_if.slave  sw
);

  localparam int unsigned   PW       = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic          start_press, disp_press;
  sw_state_e     state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          disp_q, disp_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk     (clk),
    .reset   (reset),
    .btn_n_i (sw.start_pause),
    .press_o (start_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_disp_db (
    .clk     (clk),
    .reset   (reset),
    .btn_n_i (sw.display_stop_continue),
    .press_o (disp_press)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSED: if (start_press) state_d = ST_RUN;
      ST_RUN: begin
        // Overflow wins over a coincident pause request.
        if (sw.max_reached)    state_d = ST_DONE;
        else if (start_press)  state_d = ST_PAUSED;
      end
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_PAUSED;
    endcase
  end

  // Prescaler advances on the current state only, so the fraction of a
  // count unit is kept across a pause.
  always_comb begin
    pre_d = pre_q;
    if (state_q == ST_RUN) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  always_comb begin
    disp_d = disp_q ^ disp_press;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_PAUSED;
      pre_q   <= '0;
      disp_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      disp_q  <= disp_d;
    end
  end

  assign sw.count_en = (state_q == ST_RUN) && (pre_q == PRE_LAST);
  assign sw.running  = (state_q == ST_RUN);
  assign sw.display  = disp_q;
  assign sw.state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TDIV = 5;
  localparam int          LAT  = 7;   // raw edge -> state/display update

  logic clk   = 1'b0;
  logic reset = 1'b0;

  stopwatch_ctrl_if sw_if();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       disp;
  } exp_t;

  typedef struct {
    int         btn;    // 0 start, 1 display, 2 both
    int         low;    // cycles held low
    bit         chg;    // outputs expected to change
    logic [1:0] st;
    logic       disp;
  } vec_t;

  exp_t sbq[$];
  logic       mon_en  = 1'b0;
  logic [3:0] prev    = '0;
  logic [3:0] cur;
  logic       prev_ce = 1'b0;
  exp_t       mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every change of {state,running,display} must match the
  // next scoreboard entry, including the cycle it appears in.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {sw_if.state, sw_if.running, sw_if.display};
      if (cur != prev) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: outputs became %b at cycle %0d, no change expected", cur, cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("sb_cycle", cyc, mon_e.cyc);
          check("sb_outputs", int'(cur), int'({mon_e.st, mon_e.st == 2'b01, mon_e.disp}));
        end
      end
      if (sw_if.count_en) begin
        check("ce_only_in_run", int'(sw_if.state), 1);
        check("ce_not_consecutive", int'(prev_ce), 0);
      end
      prev    = cur;
      prev_ce = sw_if.count_en;
    end
  end

  task automatic press(input int btn, input int low, input bit chg,
                       input logic [1:0] st, input logic disp,
                       input int max_off, output int c_o);
    exp_t e;
    @(posedge clk); #1;
    if (btn != 1) sw_if.start_pause = 1'b0;
    if (btn != 0) sw_if.display_stop_continue = 1'b0;
    c_o = cyc;
    if (chg) begin
      e.cyc  = c_o + LAT;
      e.st   = st;
      e.disp = disp;
      sbq.push_back(e);
    end
    for (int k = 1; k <= low; k++) begin
      @(posedge clk); #1;
      sw_if.max_reached = (k == max_off);
    end
    sw_if.start_pause = 1'b1;
    sw_if.display_stop_continue = 1'b1;
  endtask

  task automatic wait_tick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sw_if.count_en) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_timeout: no count_en within %0d cycles, required one", budget);
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    sw_if.start_pause = 1'b1;
    sw_if.display_stop_continue = 1'b1;
    sw_if.max_reached = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    sbq.delete();
    prev    = {sw_if.state, sw_if.running, sw_if.display};
    prev_ce = sw_if.count_en;
    mon_en  = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count_en"}, int'(sw_if.count_en), 0);
    check({tag, "_running"},  int'(sw_if.running),  0);
    check({tag, "_display"},  int'(sw_if.display),  1);
    check({tag, "_state"},    int'(sw_if.state),    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];
  int c, c2, t, t2;

  initial begin
    tbl[0] = '{0, 3, 1'b0, 2'b01, 1'b1};  // start glitch ignored
    tbl[1] = '{1, 6, 1'b1, 2'b01, 1'b0};  // lap freeze
    tbl[2] = '{1, 6, 1'b1, 2'b01, 1'b1};  // lap release
    tbl[3] = '{0, 6, 1'b1, 2'b00, 1'b1};  // pause
    tbl[4] = '{1, 3, 1'b0, 2'b00, 1'b1};  // display glitch ignored
    tbl[5] = '{1, 6, 1'b1, 2'b00, 1'b0};  // display toggles in PAUSED
    tbl[6] = '{2, 6, 1'b1, 2'b01, 1'b1};  // both: run + toggle
    tbl[7] = '{2, 6, 1'b1, 2'b00, 1'b0};  // both: pause + toggle
    tbl[8] = '{1, 6, 1'b1, 2'b00, 1'b1};
    tbl[9] = '{0, 6, 1'b1, 2'b01, 1'b1};  // resume

    sw_if.start_pause = 1'b1;
    sw_if.display_stop_continue = 1'b1;
    sw_if.max_reached = 1'b0;

    // Reset values and start latency / tick cadence
    do_reset();
    check_reset_outputs("reset");
    press(0, 10, 1'b1, 2'b01, 1'b1, 0, c);
    wait_tick(10, t);
    check("first_tick", t, c + LAT + 4);
    wait_tick(10, t);
    check("second_tick", t, c + LAT + 9);
    wait_tick(10, t);
    check("third_tick", t, c + LAT + 14);

    // Table-driven button sequences
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].btn, tbl[i].low, tbl[i].chg, tbl[i].st, tbl[i].disp, 0, c);
      repeat (10) @(posedge clk);
      #1;
      check($sformatf("vec%0d_state", i),   int'(sw_if.state),   int'(tbl[i].st));
      check($sformatf("vec%0d_display", i), int'(sw_if.display), int'(tbl[i].disp));
      check($sformatf("vec%0d_start_cnt", i), int'(dut.u_start_db.cnt_q), 0);
      check($sformatf("vec%0d_disp_cnt", i),  int'(dut.u_disp_db.cnt_q),  0);
      check($sformatf("vec%0d_sb_drained", i), sbq.size(), 0);
    end

    // Pause with the prescaler at 2, then resume
    wait_tick(10, t);
    @(posedge clk);
    press(0, 6, 1'b1, 2'b00, 1'b1, 0, c);
    repeat (12) @(posedge clk);
    #1;
    check("pause_prescaler_held", int'(dut.pre_q), 3);
    press(0, 6, 1'b1, 2'b01, 1'b1, 0, c2);
    wait_tick(20, t2);
    check("resume_first_tick", t2, c2 + LAT + 1);

    // Lap freeze while ticks continue
    press(1, 6, 1'b1, 2'b01, 1'b0, 0, c);
    repeat (2) @(posedge clk);
    wait_tick(10, t);
    check("lap_tick_display", int'(sw_if.display), 0);
    press(1, 6, 1'b1, 2'b01, 1'b1, 0, c);
    repeat (10) @(posedge clk);
    #1;
    check("lap_released", int'(sw_if.display), 1);

    // Overflow with a coincident start press
    press(0, 8, 1'b1, 2'b10, 1'b1, 6, c);
    repeat (6) @(posedge clk);
    #1;
    check("done_state", int'(sw_if.state), 2);
    press(0, 6, 1'b0, 2'b10, 1'b1, 0, c);
    press(1, 6, 1'b1, 2'b10, 1'b0, 0, c);
    repeat (14) @(posedge clk);
    #1;
    check("done_sticky", int'(sw_if.state), 2);
    check("done_running", int'(sw_if.running), 0);
    check("done_display", int'(sw_if.display), 0);
    check("done_sb_drained", sbq.size(), 0);
    do_reset();
    check_reset_outputs("after_done");

    // Asynchronous reset mid-tick and mid-debounce
    press(1, 6, 1'b1, 2'b00, 1'b0, 0, c);
    repeat (12) @(posedge clk);
    press(0, 6, 1'b1, 2'b01, 1'b0, 0, c);
    repeat (10) @(posedge clk);
    wait_tick(10, t);
    sw_if.display_stop_continue = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_prescaler", int'(dut.pre_q), 3);
    check("pre_reset_debounce", int'(dut.u_disp_db.cnt_q), 2);
    check("pre_reset_sb_drained", sbq.size(), 0);
    mon_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    check("async_reset_prescaler", int'(dut.pre_q), 0);
    check("async_reset_debounce", int'(dut.u_disp_db.cnt_q), 0);
    do_reset();
    check_reset_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
